// File: rtl/lmc_loader_if.sv
// lmc_loader_if: host word stream, mailbox write bus and INP handshake between host, loader and LMC core
interface lmc_loader_if #(
    parameter int WORD_W = 10,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              core_start;
    logic              inp_req;
    logic              inp_ack;
    logic [WORD_W-1:0] inp_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              err;

    modport slave (
        input  s_valid, s_data, s_last, inp_req,
        output s_ready, mem_we, mem_addr, mem_wdata, core_start,
               inp_ack, inp_data, fifo_count, err
    );

    modport master (
        output s_valid, s_data, s_last, inp_req,
        input  s_ready, mem_we, mem_addr, mem_wdata, core_start,
               inp_ack, inp_data, fifo_count, err
    );
endinterface

// File: rtl/lmc_loader.sv
// lmc_loader: loads the LMC program image, zero-fills the rest, starts the core, then feeds INP from a FIFO
module lmc_loader #(
    parameter int MEM_DEPTH  = 100,
    parameter int WORD_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    lmc_loader_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] PROG   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] START  = 2'd2;
    localparam logic [1:0] STREAM = 2'd3;

    localparam logic [AW-1:0]     LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [WORD_W-1:0] MAX_WORD  = WORD_W'(999);

    logic [1:0]        state_q, state_d;
    logic              live_q;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              core_start_q, core_start_d;
    logic              err_q, err_d;
    logic              inp_ack_q, inp_ack_d;
    logic [WORD_W-1:0] inp_data_q, inp_data_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] fifo_q [FIFO_DEPTH];

    logic s_ready;
    logic xfer;
    logic legal;
    logic push;
    logic pop;

    // live_q holds s_ready low until the first clock after reset release;
    // core_start_q keeps the host stalled through the start pulse
    assign s_ready = live_q & ((state_q == PROG) |
                     ((state_q == STREAM) & ~core_start_q & (count_q < FULL)));
    assign xfer    = bus.s_valid & s_ready;
    assign legal   = bus.s_data <= MAX_WORD;
    assign push    = xfer & legal & (state_q == STREAM);
    assign pop     = (state_q == STREAM) & bus.inp_req & (count_q != '0) & ~inp_ack_q;

    assign bus.s_ready    = s_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_start = core_start_q;
    assign bus.inp_ack    = inp_ack_q;
    assign bus.inp_data   = inp_data_q;
    assign bus.fifo_count = count_q;
    assign bus.err        = err_q;

    // load sequencing: program writes, zero fill, start pulse, then streaming
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_start_d = 1'b0;
        err_d        = err_q | (xfer & ~legal);
        case (state_q)
            PROG: begin
                if (xfer) begin
                    if (legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q;
                        mem_wdata_d = bus.s_data;
                        cnt_d       = cnt_q + AW'(1);
                    end
                    if (legal && cnt_q == LAST_ADDR)
                        state_d = START;
                    else if (bus.s_last)
                        state_d = CLEAR;
                end
            end
            CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q;
                mem_wdata_d = '0;
                cnt_d       = cnt_q + AW'(1);
                state_d     = (cnt_q == LAST_ADDR) ? START : CLEAR;
            end
            START: begin
                core_start_d = 1'b1;
                state_d      = STREAM;
            end
            default: ;
        endcase
    end

    // input FIFO bookkeeping and the registered INP acknowledge
    always_comb begin
        rd_d       = rd_q + PW'(pop);
        wr_d       = wr_q + PW'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inp_ack_d  = pop;
        inp_data_d = pop ? fifo_q[rd_q] : inp_data_q;
    end

    // control and output registers; reset abandons any load in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PROG;
            live_q       <= 1'b0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            inp_ack_q    <= 1'b0;
            inp_data_q   <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            inp_ack_q    <= inp_ack_d;
            inp_data_q   <= inp_data_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_q] <= bus.s_data;
    end
endmodule
